// File: rtl/proc_pkg.sv
// Shared definitions for the processor sequencer: opcodes, FSM states, bus-select constants.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MVNZ = 3'd4;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [9:0] SEL_DIN = 10'h001;
  localparam logic [9:0] SEL_G   = 10'h002;

  // Register n sits at bus-select bit 9-n, so R0 is the MSB.
  function automatic logic [9:0] sel_reg(input logic [2:0] n);
    sel_reg = 10'h200 >> n;
  endfunction

endpackage

// File: rtl/proc_dec3to8.sv
// Enable-gated 3-to-8 one-hot decoder; output is all-zero when disabled.
module proc_dec3to8 (
  input  logic [2:0] i_idx,
  input  logic       i_en,
  output logic [7:0] o_onehot
);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign o_onehot[gi] = i_en && (i_idx == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/proc_control_fsm.sv
// Instruction sequencer for the 16-bit processor: fetches IR in T0, steps T1..T3, drives bus/load controls.
// Optional macro PROC_MVNZ_EN enables the conditional move (opcode 100) gated by GNZ.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              GNZ,
  output logic [9:0]        BusSel,
  output logic [7:0]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done
);

  state_t          r_state;
  state_t          w_state_next;
  logic [IR_W-1:0] r_ir;

  logic [2:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic       w_rin_en;
  logic       w_bus_reg_en;
  logic [2:0] w_bus_idx;
  logic       w_sel_g;
  logic [7:0] w_bus_reg_oh;
  logic [7:0] w_bus_reg_rev;
  logic       w_unused_inputs;

  assign w_op = r_ir[IR_W-1 -: 3];
  assign w_x  = r_ir[IR_W-4 -: 3];
  assign w_y  = r_ir[IR_W-7 -: 3];

  // Low DIN bits carry immediates for the datapath only; GNZ is idle when mvnz is compiled out.
  assign w_unused_inputs = ^{DIN[DATA_W-IR_W-1:0], GNZ};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == T0 && Run) begin
        r_ir <= DIN[DATA_W-1 -: IR_W];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rin_en     = 1'b0;
    w_bus_reg_en = 1'b0;
    w_bus_idx    = w_y;
    w_sel_g      = 1'b0;
    Ain          = 1'b0;
    Gin          = 1'b0;
    AddSub       = 1'b0;
    Done         = 1'b0;
    case (r_state)
      T0: begin
        if (Run) w_state_next = T1;
      end
      T1: begin
        w_state_next = T0;
        case (w_op)
          OP_MV: begin
            w_bus_reg_en = 1'b1;
            w_rin_en     = 1'b1;
            Done         = 1'b1;
          end
          OP_MVI: begin
            w_rin_en = 1'b1;
            Done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_bus_reg_en = 1'b1;
            w_bus_idx    = w_x;
            Ain          = 1'b1;
            w_state_next = T2;
          end
`ifdef PROC_MVNZ_EN
          OP_MVNZ: begin
            w_bus_reg_en = 1'b1;
            w_rin_en     = GNZ;
            Done         = 1'b1;
          end
`endif
          default: begin
            Done = 1'b1;
          end
        endcase
      end
      T2: begin
        w_bus_reg_en = 1'b1;
        Gin          = 1'b1;
        AddSub       = (w_op == OP_SUB);
        w_state_next = T3;
      end
      T3: begin
        w_sel_g      = 1'b1;
        w_rin_en     = 1'b1;
        Done         = 1'b1;
        w_state_next = T0;
      end
      default: begin
        w_state_next = T0;
      end
    endcase
  end

  proc_dec3to8 u_rin_dec (
    .i_idx    (w_x),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

  proc_dec3to8 u_bus_dec (
    .i_idx    (w_bus_idx),
    .i_en     (w_bus_reg_en),
    .o_onehot (w_bus_reg_oh)
  );

  // Bus select orders registers R0..R7 from bit 9 downward, so the decoder output is mirrored.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
      assign w_bus_reg_rev[7-gi] = w_bus_reg_oh[gi];
    end
  endgenerate

  assign BusSel = w_bus_reg_en ? {w_bus_reg_rev, 2'b00} : (w_sel_g ? SEL_G : SEL_DIN);

endmodule

// File: tb/tb_proc_control_fsm.sv
// Self-checking bench for proc_control_fsm: directed table, reset-abort sequence, random run vs. step-list model.
module tb_proc_control_fsm;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic        GNZ;
  logic [9:0]  BusSel;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;

  proc_control_fsm #(.DATA_W(16), .IR_W(9)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .GNZ    (GNZ),
    .BusSel (BusSel),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [21:0] IDLE = {10'h001, 8'h00, 4'b0000};

  // One control step of an instruction: src -1 = DIN, -2 = G, 0..7 = register; rin -1 = none.
  typedef struct {
    int src;
    int rin;
    bit cond;
    bit ain;
    bit gin;
    bit sub;
    bit done;
  } step_t;

  typedef struct {
    bit          run;
    logic [15:0] din;
    bit          gnz;
    logic [21:0] exp;
  } vec_t;

  step_t q[$];
  vec_t  tbl[17];

  function automatic logic [21:0] pk(input logic [9:0] b, input logic [7:0] r,
                                     input logic a, input logic g, input logic s, input logic d);
    return {b, r, a, g, s, d};
  endfunction

  function automatic step_t mk(input int src, input int rin, input bit cond,
                               input bit a, input bit g, input bit s, input bit d);
    step_t st;
    st.src = src; st.rin = rin; st.cond = cond;
    st.ain = a; st.gin = g; st.sub = s; st.done = d;
    return st;
  endfunction

  function automatic logic [21:0] expect_of(input step_t st, input bit gnz);
    logic [9:0] b;
    logic [7:0] r;
    if (st.src == -1)      b = 10'h001;
    else if (st.src == -2) b = 10'h002;
    else                   b = 10'h200 >> st.src;
    r = (st.rin >= 0 && (!st.cond || gnz)) ? (8'h01 << st.rin) : 8'h00;
    return {b, r, st.ain, st.gin, st.sub, st.done};
  endfunction

  task automatic push_instr(input logic [15:0] d);
    int op, x, y;
    op = int'(d[15:13]);
    x  = int'(d[12:10]);
    y  = int'(d[9:7]);
    case (op)
      0: q.push_back(mk(y, x, 0, 0, 0, 0, 1));
      1: q.push_back(mk(-1, x, 0, 0, 0, 0, 1));
      2, 3: begin
        q.push_back(mk(x, -1, 0, 1, 0, 0, 0));
        q.push_back(mk(y, -1, 0, 0, 1, op == 3, 0));
        q.push_back(mk(-2, x, 0, 0, 0, 0, 1));
      end
`ifdef PROC_MVNZ_EN
      4: q.push_back(mk(y, x, 1, 0, 0, 0, 1));
`endif
      default: q.push_back(mk(-1, -1, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic check(input string name, input logic [21:0] exp);
    logic [21:0] got;
    got = {BusSel, Rin, Ain, Gin, AddSub, Done};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got bus=%h rin=%h agsd=%b, required bus=%h rin=%h agsd=%b",
               name, got[21:12], got[11:4], got[3:0], exp[21:12], exp[11:4], exp[3:0]);
    end else begin
      $display("ok   %s: bus=%h rin=%h agsd=%b", name, got[21:12], got[11:4], got[3:0]);
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 16'h0000;
    GNZ    = 1'b0;
    #1;
    check("reset", IDLE);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      Run = 1'b0; DIN = 16'($urandom);
      #1;
      check($sformatf("idle%0d", i), IDLE);
    end

    tbl[0]  = '{1'b1, 16'h2400, 1'b0, IDLE};
    tbl[1]  = '{1'b0, 16'h0005, 1'b0, pk(10'h001, 8'h02, 0, 0, 0, 1)};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, IDLE};
    tbl[3]  = '{1'b1, 16'h4080, 1'b0, IDLE};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, pk(10'h200, 8'h00, 1, 0, 0, 0)};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, pk(10'h100, 8'h00, 0, 1, 0, 0)};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, pk(10'h002, 8'h01, 0, 0, 0, 1)};
    tbl[7]  = '{1'b1, 16'h7FC0, 1'b0, IDLE};
    tbl[8]  = '{1'b1, 16'h2400, 1'b0, pk(10'h004, 8'h00, 1, 0, 0, 0)};
    tbl[9]  = '{1'b1, 16'h2400, 1'b0, pk(10'h004, 8'h00, 0, 1, 1, 0)};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, pk(10'h002, 8'h80, 0, 0, 0, 1)};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, IDLE};
    tbl[12] = '{1'b1, 16'h8E00, 1'b0, IDLE};
`ifdef PROC_MVNZ_EN
    tbl[13] = '{1'b0, 16'h0000, 1'b0, pk(10'h020, 8'h00, 0, 0, 0, 1)};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, pk(10'h020, 8'h08, 0, 0, 0, 1)};
`else
    tbl[13] = '{1'b0, 16'h0000, 1'b0, pk(10'h001, 8'h00, 0, 0, 0, 1)};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, pk(10'h001, 8'h00, 0, 0, 0, 1)};
`endif
    tbl[14] = '{1'b1, 16'h8E00, 1'b0, IDLE};
    tbl[16] = '{1'b0, 16'h0000, 1'b0, IDLE};

    for (int i = 0; i < 17; i++) begin
      @(negedge Clock);
      Run = tbl[i].run; DIN = tbl[i].din; GNZ = tbl[i].gnz;
      #1;
      check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Reset asserted during T2 of add R0,R1 must abort with no trailing Rin.
    @(negedge Clock);
    Run = 1'b1; DIN = 16'h4080; GNZ = 1'b0;
    #1 check("abort_t0", IDLE);
    @(negedge Clock);
    Run = 1'b0;
    #1 check("abort_t1", pk(10'h200, 8'h00, 1, 0, 0, 0));
    @(negedge Clock);
    #1 check("abort_t2", pk(10'h100, 8'h00, 0, 1, 0, 0));
    Resetn = 1'b0;
    #1 check("abort_rst", IDLE);
    @(negedge Clock);
    Resetn = 1'b1;
    #1 check("abort_rel", IDLE);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      #1 check($sformatf("abort_after%0d", i), IDLE);
    end

    q.delete();
    for (int i = 0; i < 400; i++) begin
      logic [21:0] exp;
      @(negedge Clock);
      Run = 1'($urandom_range(0, 1));
      DIN = 16'($urandom);
      GNZ = 1'($urandom_range(0, 1));
      #1;
      exp = (q.size() == 0) ? IDLE : expect_of(q[0], GNZ);
      check($sformatf("rnd%0d", i), exp);
      if (q.size() == 0) begin
        if (Run) push_instr(DIN);
      end else begin
        void'(q.pop_front());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
